// File: rtl/jtframe_frac_cenx_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_frac_cenx_if
//  Brief    : Ratio-load / clock-enable bundle for jtframe_frac_cenx.
//  Revision : 1.0  initial release
// ============================================================================
interface jtframe_frac_cenx_if #(
    parameter int W  = 4,
    parameter int WC = 10
);
    logic [WC-1:0] n;
    logic [WC-1:0] m;
    logic          load;
    logic          en;
    logic [W-1:0]  cen;
    logic [W-1:0]  cenb;
    logic          busy;

    modport master (
        output n, m, load, en,
        input  cen, cenb, busy
    );

    modport slave (
        input  n, m, load, en,
        output cen, cenb, busy
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_frac_cenx.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_frac_cenx
//  Brief    : Fractional n/m clock-enable generator with binary sub-rates.
//  Revision : 1.0  initial release
// ============================================================================
module jtframe_frac_cenx #(
    parameter int W     = 4,
    parameter int WC    = 10,
    parameter int N_RST = 1,
    parameter int M_RST = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    jtframe_frac_cenx_if.slave cen_if
);

    localparam logic [WC-1:0] c_n_rst    = WC'(N_RST);
    localparam logic [WC-1:0] c_m_rst    = WC'(M_RST);
    localparam logic          c_busy_rst = (N_RST != 0) && (M_RST != 0);

    logic [WC-1:0] rn_q,   rn_d;
    logic [WC-1:0] rm_q,   rm_d;
    logic [WC-1:0] acc_q,  acc_d;
    logic [W-1:0]  e_q,    e_d;
    logic [W-1:0]  cen_q,  cen_d;
    logic [W-1:0]  cenb_q, cenb_d;
    logic          busy_q, busy_d;

    logic [WC:0]   w_sum;
    logic          w_sat;
    logic          w_base;

    // One spare bit so acc+rn cannot wrap before the compare against rm.
    assign w_sum  = {1'b0, acc_q} + {1'b0, rn_q};
    assign w_sat  = (rn_q >= rm_q);
    assign w_base = cen_if.en & ~cen_if.load & busy_q & (w_sum >= {1'b0, rm_q});

    for (genvar i = 0; i < W; i++) begin : g_pulse
        if (i == 0) begin : g_base
            assign cen_d[i]  = w_base;
            assign cenb_d[i] = 1'b0;
        end else begin : g_div
            localparam int unsigned c_half = 32'd1 << (i - 1);
            assign cen_d[i]  = w_base & (e_q[i-1:0] == '0);
            assign cenb_d[i] = w_base & (e_q[i-1:0] == c_half[i-1:0]);
        end
    end

    always_comb begin
        rn_d   = rn_q;
        rm_d   = rm_q;
        acc_d  = acc_q;
        e_d    = e_q;
        busy_d = busy_q;
        if (cen_if.load) begin
            rn_d   = cen_if.n;
            rm_d   = cen_if.m;
            acc_d  = '0;
            e_d    = '0;
            busy_d = (cen_if.n != '0) && (cen_if.m != '0);
        end else if (cen_if.en && busy_q) begin
            // A ratio of one or more saturates: fire every cycle, keep phase at zero.
            if (w_sat) begin
                acc_d = '0;
            end else if (w_base) begin
                acc_d = WC'(w_sum - {1'b0, rm_q});
            end else begin
                acc_d = w_sum[WC-1:0];
            end
            if (w_base) begin
                e_d = e_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rn_q   <= c_n_rst;
            rm_q   <= c_m_rst;
            acc_q  <= '0;
            e_q    <= '0;
            cen_q  <= '0;
            cenb_q <= '0;
            busy_q <= c_busy_rst;
        end else begin
            rn_q   <= rn_d;
            rm_q   <= rm_d;
            acc_q  <= acc_d;
            e_q    <= e_d;
            cen_q  <= cen_d;
            cenb_q <= cenb_d;
            busy_q <= busy_d;
        end
    end

    assign cen_if.cen  = cen_q;
    assign cen_if.cenb = cenb_q;
    assign cen_if.busy = busy_q;

endmodule
`default_nettype wire
